// File: rtl/popcount_stream.sv
// popcount_stream: counts set bits of TKEEP-masked stream beats plus MMIO words through a 2-stage pipeline
// Ports:
//   S_AXIS_ACLK, S_AXIS_ARESETN          clock, asynchronous active-low reset
//   S_AXIS_TDATA/TKEEP/TLAST/TVALID      stream beat in; S_AXIS_TREADY accept
//   WRITE_DATA, WRITE_VALID              MMIO word to count (all bytes)
//   COUNT, COUNT_RST, COUNT_BUSY         running total, sync clear/flush, busy flag
//   LAST_COUNT, LAST_VALID               total of last completed packet, update pulse
//   OVERFLOW                             sticky COUNT wrap/clamp flag
module popcount_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32,
    parameter int SATURATE    = 0
) (
    input  logic                      S_AXIS_ACLK,
    input  logic                      S_AXIS_ARESETN,
    input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
    input  logic                      S_AXIS_TLAST,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]     WRITE_DATA,
    input  logic                      WRITE_VALID,
    output logic [COUNT_WIDTH-1:0]    COUNT,
    input  logic                      COUNT_RST,
    output logic                      COUNT_BUSY,
    output logic [COUNT_WIDTH-1:0]    LAST_COUNT,
    output logic                      LAST_VALID,
    output logic                      OVERFLOW
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int SW = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state, state_next;
    logic                   beat_acc, wr_acc;
    logic [DATA_WIDTH-1:0]  kept;
    logic [SW-1:0]          sum_next, s1_sum;
    logic                   s1_valid, s1_last;
    logic [COUNT_WIDTH:0]   count_add, pkt_add;
    logic [COUNT_WIDTH-1:0] count_next, pkt_next, pkt_acc;

    function automatic logic [SW-1:0] popcount(input logic [DATA_WIDTH-1:0] d);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_WIDTH; i++) n += SW'(d[i]);
        return n;
    endfunction

    assign S_AXIS_TREADY = S_AXIS_ARESETN & ~COUNT_RST;
    assign beat_acc      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign wr_acc        = WRITE_VALID & ~COUNT_RST;
    assign COUNT_BUSY    = s1_valid | (state == IN_PKT);

    always_comb begin
        kept = '0;
        for (int i = 0; i < KW; i++) kept[i*8 +: 8] = S_AXIS_TKEEP[i] ? S_AXIS_TDATA[i*8 +: 8] : 8'h00;
        sum_next = (beat_acc ? popcount(kept) : '0) + (wr_acc ? popcount(WRITE_DATA) : '0);
    end

    // One extra bit catches the carry; SATURATE chooses clamp vs wrap.
    always_comb begin
        count_add  = {1'b0, COUNT} + (COUNT_WIDTH+1)'(s1_sum);
        pkt_add    = {1'b0, pkt_acc} + (COUNT_WIDTH+1)'(s1_sum);
        count_next = (count_add[COUNT_WIDTH] && SATURATE != 0) ? '1 : count_add[COUNT_WIDTH-1:0];
        pkt_next   = (pkt_add[COUNT_WIDTH] && SATURATE != 0) ? '1 : pkt_add[COUNT_WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        if (beat_acc) state_next = S_AXIS_TLAST ? IDLE : IN_PKT;
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN)
            state <= IDLE;
        else if (COUNT_RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s1_last    <= 1'b0;
            COUNT      <= '0;
            pkt_acc    <= '0;
            LAST_COUNT <= '0;
            LAST_VALID <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else if (COUNT_RST) begin
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s1_last    <= 1'b0;
            COUNT      <= '0;
            pkt_acc    <= '0;
            LAST_COUNT <= '0;
            LAST_VALID <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            s1_valid   <= beat_acc | wr_acc;
            s1_sum     <= sum_next;
            s1_last    <= beat_acc & S_AXIS_TLAST;
            LAST_VALID <= s1_valid & s1_last;
            if (s1_valid) begin
                COUNT    <= count_next;
                OVERFLOW <= OVERFLOW | count_add[COUNT_WIDTH];
                if (s1_last) begin
                    LAST_COUNT <= pkt_next;
                    pkt_acc    <= '0;
                end else begin
                    pkt_acc <= pkt_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_popcount_stream.sv
// tb_popcount_stream: scoreboard bench for popcount_stream (32-bit wrap, 8-bit saturate, 8-bit wrap instances)
module tb_popcount_stream;
    logic        clk, rst_n;
    logic [31:0] tdata, wdata;
    logic [3:0]  tkeep;
    logic        tlast, tvalid, wvalid, count_rst;
    logic        tready, busy, last_valid, ovf;
    logic [31:0] count, last_count;
    logic        tready_s, busy_s, lv_s, ovf_s, tready_w, busy_w, lv_w, ovf_w;
    logic [7:0]  count_s, lc_s, count_w, lc_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] lc;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];

    popcount_stream dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TLAST(tlast), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
        .WRITE_DATA(wdata), .WRITE_VALID(wvalid), .COUNT(count), .COUNT_RST(count_rst),
        .COUNT_BUSY(busy), .LAST_COUNT(last_count), .LAST_VALID(last_valid), .OVERFLOW(ovf)
    );

    popcount_stream #(.COUNT_WIDTH(8), .SATURATE(1)) dut_s8 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TLAST(tlast), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready_s),
        .WRITE_DATA(wdata), .WRITE_VALID(wvalid), .COUNT(count_s), .COUNT_RST(count_rst),
        .COUNT_BUSY(busy_s), .LAST_COUNT(lc_s), .LAST_VALID(lv_s), .OVERFLOW(ovf_s)
    );

    popcount_stream #(.COUNT_WIDTH(8), .SATURATE(0)) dut_w8 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TDATA(tdata), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TLAST(tlast), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready_w),
        .WRITE_DATA(wdata), .WRITE_VALID(wvalid), .COUNT(count_w), .COUNT_RST(count_rst),
        .COUNT_BUSY(busy_w), .LAST_COUNT(lc_w), .LAST_VALID(lv_w), .OVERFLOW(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
    endtask

    task automatic idle();
        tvalid = 1'b0;
        wvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic push(input logic [31:0] lc, input logic [31:0] cnt);
        exp_t e;
        e.lc  = lc;
        e.cnt = cnt;
        q.push_back(e);
    endtask

    // Monitor: every LAST_VALID pulse must match the oldest expected packet result.
    always @(negedge clk) begin
        if (last_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_last_valid actual=%0d required=none", last_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("last_count", 64'(last_count), 64'(e.lc));
                check("count_at_last", 64'(count), 64'(e.cnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0; count_rst = 1'b0;
        tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
        wdata = '0; wvalid = 1'b0;
        @(negedge clk);
        check("rst_count", 64'(count), 0);
        check("rst_last_count", 64'(last_count), 0);
        check("rst_last_valid", 64'(last_valid), 0);
        check("rst_overflow", 64'(ovf), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_tready", 64'(tready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single full beat with TLAST
        beat(32'hFFFF_FFFF, 4'hF, 1'b1);
        push(32, 32);
        @(negedge clk);
        idle();
        check("t1_busy_n1", 64'(busy), 1);
        check("t1_count_n1", 64'(count), 0);
        @(negedge clk);
        check("t1_count_n2", 64'(count), 32);
        check("t1_busy_n2", 64'(busy), 0);
        @(negedge clk);
        check("t1_last_valid_one_cycle", 64'(last_valid), 0);

        // 3-beat back-to-back packet
        beat(32'h0000_000F, 4'hF, 1'b0);
        #1 check("t2_tready0", 64'(tready), 1);
        @(negedge clk);
        check("t2_busy1", 64'(busy), 1);
        beat(32'hFFFF_FFFF, 4'h3, 1'b0);
        #1 check("t2_tready1", 64'(tready), 1);
        @(negedge clk);
        check("t2_busy2", 64'(busy), 1);
        beat(32'h8000_0000, 4'h8, 1'b1);
        push(21, 53);
        @(negedge clk);
        check("t2_busy3", 64'(busy), 1);
        idle();
        @(negedge clk);
        check("t2_count", 64'(count), 53);
        check("t2_busy_done", 64'(busy), 0);

        // simultaneous MMIO write and beat, then an empty TLAST beat
        beat(32'h0000_00FF, 4'hF, 1'b0);
        wvalid = 1'b1;
        wdata  = 32'h0000_000F;
        @(negedge clk);
        wvalid = 1'b0;
        beat(32'h0000_0000, 4'hF, 1'b1);
        push(12, 65);
        @(negedge clk);
        idle();
        check("t3_count", 64'(count), 65);
        @(negedge clk);
        @(negedge clk);

        // overflow on 8-bit instances after a clear
        count_rst = 1'b1;
        @(negedge clk);
        count_rst = 1'b0;
        check("t4_cleared_count", 64'(count), 0);
        for (int i = 0; i < 9; i++) begin
            beat(32'hFFFF_FFFF, 4'hF, i == 8);
            @(negedge clk);
        end
        push(288, 288);
        idle();
        @(negedge clk);
        check("t4_sat_count", 64'(count_s), 255);
        check("t4_sat_ovf", 64'(ovf_s), 1);
        check("t4_sat_last", 64'(lc_s), 255);
        check("t4_wrap_count", 64'(count_w), 32);
        check("t4_wrap_ovf", 64'(ovf_w), 1);
        check("t4_wrap_last", 64'(lc_w), 32);
        check("t4_main_ovf", 64'(ovf), 0);
        @(negedge clk);

        // COUNT_RST with a beat in stage 1
        beat(32'h0000_00FF, 4'hF, 1'b0);
        @(negedge clk);
        count_rst = 1'b1;
        beat(32'h0000_FFFF, 4'hF, 1'b1);
        #1 check("t5_tready_in_rst", 64'(tready), 0);
        @(negedge clk);
        count_rst = 1'b0;
        idle();
        check("t5_count", 64'(count), 0);
        check("t5_busy", 64'(busy), 0);
        check("t5_sat_ovf_cleared", 64'(ovf_s), 0);
        check("t5_sat_count", 64'(count_s), 0);
        @(negedge clk);
        check("t5_count_after", 64'(count), 0);
        @(negedge clk);

        // async reset mid-packet
        beat(32'h0000_00FF, 4'hF, 1'b0);
        @(negedge clk);
        beat(32'h0000_0003, 4'hF, 1'b0);
        @(negedge clk);
        check("t6_count_before", 64'(count), 8);
        check("t6_busy_before", 64'(busy), 1);
        beat(32'h0000_0001, 4'hF, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_count_async", 64'(count), 0);
        check("t6_busy_async", 64'(busy), 0);
        check("t6_tready_async", 64'(tready), 0);
        check("t6_last_valid_async", 64'(last_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(1, 1);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("t6_count_after", 64'(count), 1);
        @(negedge clk);
        @(negedge clk);
        check("pending_last", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/popcount_stream.md
Name: popcount_stream

Overview:
Parametrised successor to the single-word AXI4-Stream popcount engine. It counts the set bits of every accepted stream beat, masked by TKEEP, plus any MMIO-written word. Counting runs through a 2-stage pipeline into a running total and a per-packet total. It sits behind the DMA MM2S channel; COUNT, LAST_COUNT and status are read back over MMIO.

Parameters:
DATA_WIDTH, 32, stream/MMIO data width in bits; multiple of 8, range 8..256
COUNT_WIDTH, 32, width of the COUNT and LAST_COUNT accumulators; must be ≥ log2(2*DATA_WIDTH)+1
SATURATE, 0, overflow mode: 0 = wrap modulo 2^COUNT_WIDTH, 1 = clamp at all-ones

Ports:
S_AXIS_ACLK  in  1  clock
S_AXIS_ARESETN  in  1  asynchronous active-low reset
S_AXIS_TDATA  in  DATA_WIDTH  stream data
S_AXIS_TKEEP  in  DATA_WIDTH/8  byte qualifiers; byte i counted only if TKEEP[i]=1
S_AXIS_TLAST  in  1  last beat of a DMA packet
S_AXIS_TVALID  in  1  beat valid
S_AXIS_TREADY  out  1  beat accept
WRITE_DATA  in  DATA_WIDTH  MMIO word to count; all bytes counted
WRITE_VALID  in  1  one-cycle MMIO write strobe
COUNT  out  COUNT_WIDTH  running total of counted bits
COUNT_RST  in  1  synchronous clear and flush
COUNT_BUSY  out  1  counting in progress
LAST_COUNT  out  COUNT_WIDTH  bit total of the most recently completed packet
LAST_VALID  out  1  one-cycle pulse when LAST_COUNT updates
OVERFLOW  out  1  sticky flag: COUNT wrapped or clamped

Behaviour:
- Async reset: all registers clear, so COUNT, LAST_COUNT, LAST_VALID, OVERFLOW and COUNT_BUSY are 0.
- S_AXIS_TREADY = S_AXIS_ARESETN & ~COUNT_RST. It is combinational and never depends on TVALID.
- A beat is accepted on a cycle where TVALID & TREADY. A write is accepted on a cycle where WRITE_VALID & ~COUNT_RST.
- Stage 1 (register at end of accept cycle N):
  - s1_sum = popcount(TDATA masked per byte by TKEEP) + popcount(WRITE_DATA), with each term 0 if not accepted.
  - s1_valid is set on any acceptance.
  - s1_last = accepted TLAST.
- Stage 2 (end of cycle N+1), when s1_valid:
  - COUNT += s1_sum.
  - pkt_acc += s1_sum.
  - If s1_last: LAST_COUNT = pkt_acc + s1_sum, pkt_acc = 0, LAST_VALID = 1 for one cycle.
- Latency: a beat accepted in cycle N is reflected in COUNT and LAST_COUNT from cycle N+2.
- Full throughput: one beat plus one write per cycle, no stalls. A simultaneous stream beat and MMIO write are both counted in the same s1_sum.
- TKEEP = 0 beat: accepted, contributes 0, and its TLAST is still honoured (LAST_VALID pulses).
- A write counts toward COUNT and toward the open packet's pkt_acc.
- Packet state machine (IDLE/IN_PKT):
  - IDLE → IN_PKT on an accepted beat with TLAST=0.
  - IN_PKT → IDLE on an accepted beat with TLAST=1.
  - A single-beat packet (TLAST=1 while IDLE) stays IDLE.
- COUNT_BUSY = s1_valid | (state==IN_PKT), both registered. It falls in the same cycle COUNT becomes final.
- Overflow:
  - The addition uses COUNT_WIDTH+1 bits.
  - On carry, SATURATE=1 clamps COUNT to all-ones; SATURATE=0 keeps the low bits.
  - OVERFLOW sets on carry in either mode. The same rule applies to pkt_acc and LAST_COUNT, but only COUNT sets OVERFLOW.
- COUNT_RST (synchronous, priority over everything):
  - Clears COUNT, pkt_acc, LAST_COUNT, LAST_VALID, OVERFLOW, s1_valid and state.
  - In-flight stage-1 data is discarded, and no beats or writes are accepted that cycle.
  - COUNT reads 0 from the following cycle. A new beat can be accepted on the first cycle COUNT_RST is low.
- Async reset mid-packet: a beat held on TVALID after release is treated as the start of a new packet.

Test Plan:
- Beat TDATA=0xFFFFFFFF, TKEEP=0xF, TLAST=1 at cycle N → COUNT=32 at N+2; LAST_COUNT=32 with a LAST_VALID pulse at N+2; COUNT_BUSY=1 only in N+1.
- 3-beat packet 0x0000000F/TKEEP 0xF, 0xFFFFFFFF/TKEEP 0x3, 0x80000000/TKEEP 0x8 with TLAST, back-to-back → COUNT=4+16+1=21, LAST_COUNT=21; COUNT_BUSY high from the first acceptance+1 until COUNT=21; TREADY held 1 throughout.
- Same cycle: WRITE_VALID with 0x0000000F and beat 0x000000FF (TKEEP 0xF, TLAST=0) → COUNT += 12 two cycles later; a following TLAST beat of 0 gives LAST_COUNT=12.
- COUNT_WIDTH=8: 9 full beats of 0xFFFFFFFF → SATURATE=1 gives COUNT=255, OVERFLOW=1; SATURATE=0 gives COUNT=288 mod 256=32, OVERFLOW=1.
- Pulse COUNT_RST mid-packet with one beat in stage 1 → TREADY=0 that cycle; next cycle COUNT=0, COUNT_BUSY=0, OVERFLOW=0; the discarded beat never appears in COUNT.
- Assert S_AXIS_ARESETN=0 asynchronously mid-clock during a packet → all outputs 0 immediately, TREADY=0; after release, a new 1-beat packet of 0x00000001 gives COUNT=1, LAST_COUNT=1.
